s2p_deser: RTL

Parametrised, single-clock serial-to-parallel deserializer with sync-word frame alignment and a valid/ready output handshake. It qualifies serial bits with a strobe instead of a separate serial clock. It hunts for a configurable sync word, then assembles WIDTH-bit words in MSB- or LSB-first order and holds each word in an output register until a downstream consumer accepts it. It sits between a serial line receiver and word-oriented datapath logic.

---
 rtl/s2p_pkg.sv | 16 +
 rtl/s2p_shift.sv | 34 +++
 rtl/s2p_deser.sv | 121 ++++++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// Shared types and helpers for the s2p_deser serial-to-parallel deserializer.
package s2p_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } s2p_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Wide enough to count 0..width, covering a trailing parity bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/s2p_shift.sv
// WIDTH-bit serial shift register with selectable fill direction and sync clear.
module s2p_shift #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_q_next
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;

    // First bit shifted in ends up at [WIDTH-1] (MSB_FIRST) or [0] after WIDTH shifts.
    always_comb begin
        if (MSB_FIRST) w_shifted = {r_q[WIDTH-2:0], i_bit};
        else           w_shifted = {i_bit, r_q[WIDTH-1:1]};
    end

    always_comb begin
        o_q_next = r_q;
        if (i_clr)     o_q_next = '0;
        else if (i_en) o_q_next = w_shifted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else        r_q <= o_q_next;
    end

endmodule

// File: rtl/s2p_deser.sv
// Strobe-qualified serial-to-parallel deserializer with sync-word alignment and
// valid/ready output. Define S2P_PARITY_EN for a trailing even-parity bit per frame.
module s2p_deser
    import s2p_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SYNC_DEFAULT),
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             resync,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             locked,
    output logic             overflow,
    input  logic             clr_ovf
`ifdef S2P_PARITY_EN
   ,output logic             parity_err
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);
`ifdef S2P_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif

    s2p_state_t       r_state, w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_hist_next, w_asm_next;
    logic [WIDTH-1:0] r_word_out;
    logic             r_word_valid, r_overflow;
    logic             w_accept, w_hunt_shift, w_lock_bit, w_asm_shift;
    logic             w_match, w_done, w_load;

    assign w_accept     = bit_valid & ~resync;
    assign w_hunt_shift = w_accept & (r_state == HUNT);
    assign w_lock_bit   = w_accept & (r_state == LOCKED);
    assign w_match      = w_hunt_shift & (w_hist_next == SYNC_WORD);
    assign w_asm_shift  = w_lock_bit & (r_cnt < CW'(WIDTH));
    assign w_done       = w_lock_bit & (r_cnt == CW'(FRAME - 1));
    assign w_load       = w_done & (~r_word_valid | word_ready);

    // History is always MSB-first so it compares against SYNC_WORD in arrival order.
    s2p_shift #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_hist (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_clr    (resync),
        .i_en     (w_hunt_shift),
        .i_bit    (bit_in),
        .o_q_next (w_hist_next)
    );

    // On the parity bit the shift is disabled, so o_q_next is the held data word.
    s2p_shift #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_asm (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_clr    (resync),
        .i_en     (w_asm_shift),
        .i_bit    (bit_in),
        .o_q_next (w_asm_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= HUNT;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (resync)       w_state_next = HUNT;
        else if (w_match) w_state_next = LOCKED;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     r_cnt <= '0;
        else if (resync || w_match || w_done) r_cnt <= '0;
        else if (w_lock_bit)              r_cnt <= r_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
        end else if (w_load) begin
            r_word_out   <= w_asm_next;
            r_word_valid <= 1'b1;
        end else if (r_word_valid && word_ready) begin
            r_word_valid <= 1'b0;
        end
    end

    // A dropped word outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              r_overflow <= 1'b0;
        else if (w_done && !w_load) r_overflow <= 1'b1;
        else if (clr_ovf)          r_overflow <= 1'b0;
    end

`ifdef S2P_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_parity_err <= 1'b0;
        else if (w_load) r_parity_err <= (^w_asm_next) ^ bit_in;
    end

    assign parity_err = r_parity_err;
`endif

    assign word_out   = r_word_out;
    assign word_valid = r_word_valid;
    assign overflow   = r_overflow;
    assign locked     = (r_state == LOCKED);

endmodule
